// File: rtl/mii_tx_framer.sv
// mii_tx_framer: sends block-RAM payload words on MII with preamble, SFD and inter-frame gap.
// Define MII_TX_FCS_EN to append a CRC-32 FCS after the payload.
module mii_tx_framer #(
    parameter int ADDR_W           = 9,
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int IFG_NIBBLES      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_count,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              busy,
    output logic              done,
    output logic              eth_tx_en,
    output logic [3:0]        eth_txd
);
    localparam int CMAX = PREAMBLE_NIBBLES > IFG_NIBBLES ? PREAMBLE_NIBBLES : IFG_NIBBLES;
    localparam int CW   = CMAX > 2 ? $clog2(CMAX) : 1;
`ifdef MII_TX_FCS_EN
    localparam logic FCS_EN = 1'b1;
`else
    localparam logic FCS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, FCS, IFG} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [2:0]        nib;
    logic [ADDR_W-1:0] word, count;
    logic [31:0]       shift, load_val;
    logic [3:0]        txd_n;
    logic              load, last_word;

`ifdef MII_TX_FCS_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c ^ {28'd0, d};
        for (int i = 0; i < 4; i++)
            r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= '1;
        else if (state == IDLE)
            crc <= '1;
        else if (state_n == DATA)
            crc <= crc_nib(crc, txd_n);
    end
`endif

    always_comb begin
        state_n   = state;
        last_word = word == count - 1'b1;
        unique case (state)
            IDLE:    if (start && word_count != '0) state_n = PRE;
            PRE:     if (cnt == CW'(PREAMBLE_NIBBLES - 1)) state_n = SFD;
            SFD:     state_n = DATA;
            DATA:    if (nib == 3'd7 && last_word) state_n = FCS_EN ? FCS : IFG;
            FCS:     if (nib == 3'd7) state_n = IFG;
            IFG:     if (cnt == CW'(IFG_NIBBLES - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        cnt_n = state_n == state ? cnt + 1'b1 : '0;
        // The shift register reloads with the next RAM word, or with the inverted CRC after the last word.
        load = state == SFD || (state == DATA && nib == 3'd7);
`ifdef MII_TX_FCS_EN
        load_val = state == DATA && last_word ? ~crc : rd_data;
`else
        load_val = rd_data;
`endif
        txd_n = state_n == PRE ? 4'h5 :
                state_n == SFD ? 4'hd :
                (state_n == DATA || state_n == FCS) ? (load ? load_val[3:0] : shift[7:4]) : 4'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            nib       <= '0;
            word      <= '0;
            count     <= '0;
            shift     <= '0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eth_tx_en <= 1'b0;
            eth_txd   <= 4'h0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            nib   <= (state == DATA || state == FCS) ? nib + 1'b1 : '0;
            shift <= load ? load_val : shift >> 4;
            if (state == IDLE && state_n == PRE) begin
                count   <= word_count;
                word    <= '0;
                rd_addr <= '0;
            end else begin
                if (state == DATA && nib == 3'd7 && !last_word)
                    word <= word + 1'b1;
                // Address runs one word ahead of the shifter but never past the last word.
                if (load && rd_addr != count - 1'b1)
                    rd_addr <= rd_addr + 1'b1;
            end
            busy      <= state_n != IDLE;
            done      <= state_n == IFG && cnt_n == CW'(IFG_NIBBLES - 1);
            eth_tx_en <= state_n inside {PRE, SFD, DATA, FCS};
            eth_txd   <= txd_n;
        end
    end
endmodule

// File: tb/tb_mii_tx_framer.sv
// tb_mii_tx_framer: directed checks of the MII transmit framer against hand-computed frames.
module tb_mii_tx_framer;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [8:0]  word_count = '0, rd_addr;
    logic [31:0] rd_data;
    logic        busy, done, eth_tx_en;
    logic [3:0]  eth_txd;

    logic [31:0] ram [0:511];
    logic [3:0]  nib [0:127];
    logic [8:0]  adr [0:127];
    int          total = 0, bad = 0, en_len, gap, pre5;
    logic [8:0]  amax;
    logic [5:0]  acc;

`ifdef MII_TX_FCS_EN
    localparam int FX = 8;
`else
    localparam int FX = 0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= ram[rd_addr];

    mii_tx_framer dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .eth_tx_en(eth_tx_en), .eth_txd(eth_txd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int b);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = nib[b + i];
        return r;
    endfunction

    task automatic capture(input int n, input int inj);
        @(negedge clk);
        start = 1'b1;
        word_count = n[8:0];
        @(negedge clk);
        start = 1'b0;
        check("latency", {31'd0, eth_tx_en}, 1);
        en_len = 0;
        amax = '0;
        while (eth_tx_en && en_len < 128) begin
            nib[en_len] = eth_txd;
            adr[en_len] = rd_addr;
            if (rd_addr > amax) amax = rd_addr;
            start = en_len == inj;
            if (start) word_count = 9'd5;
            en_len++;
            @(negedge clk);
        end
        start = 1'b0;
        gap = 1;
        while (!done && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        pre5 = 0;
        for (int i = 0; i < 15; i++) if (nib[i] == 4'h5) pre5++;
        check("preamble", pre5, 15);
        check("sfd", {28'd0, nib[15]}, 32'hd);
        check("done_gap", gap, 24);
    endtask

    initial begin
        ram[0] = 32'h44332211;
        repeat (3) @(negedge clk);
        check("rst_en", {31'd0, eth_tx_en}, 0);
        check("rst_txd", {28'd0, eth_txd}, 0);
        check("rst_addr", {23'd0, rd_addr}, 0);
        check("rst_busy_done", {30'd0, busy, done}, 0);
        rst = 1'b0;
        acc = '0;
        repeat (50) begin
            @(negedge clk);
            acc |= {eth_tx_en, eth_txd, busy};
        end
        check("idle", {26'd0, acc}, 0);

        capture(1, -1);
        check("len1", en_len, 24 + FX);
        check("word1", wd(16), 32'h44332211);
        // start on the done cycle must be ignored
        start = 1'b1;
        word_count = 9'd1;
        @(negedge clk);
        start = 1'b0;
        check("done_start_ign", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);

        ram[0] = 32'h0;
        capture(1, -1);
        check("len_zero", en_len, 24 + FX);
        check("word_zero", wd(16), 32'h0);
`ifdef MII_TX_FCS_EN
        check("fcs_zero", wd(24), 32'h2144DF1C);
`endif

        ram[0] = 32'h89ABCDEF;
        ram[1] = 32'h01234567;
        ram[2] = 32'hDEADBEEF;
        ram[3] = 32'hBADBAD00;
        capture(3, -1);
        check("len3", en_len, 40 + FX);
        check("w3_0", wd(16), 32'h89ABCDEF);
        check("w3_1", wd(24), 32'h01234567);
        check("w3_2", wd(32), 32'hDEADBEEF);
        check("addr_pre", {23'd0, adr[0]}, 0);
        check("addr_sfd", {23'd0, adr[15]}, 0);
        check("addr_d0", {23'd0, adr[16]}, 1);
        check("addr_d7", {23'd0, adr[23]}, 1);
        check("addr_d8", {23'd0, adr[24]}, 2);
        check("addr_d23", {23'd0, adr[39]}, 2);
        check("addr_max", {23'd0, amax}, 2);

        capture(2, 20);
        check("len_inj", en_len, 32 + FX);
        check("inj_w0", wd(16), 32'h89ABCDEF);
        check("inj_w1", wd(24), 32'h01234567);
        repeat (2) @(negedge clk);
        start = 1'b1;
        word_count = 9'd0;
        @(negedge clk);
        start = 1'b0;
        acc = '0;
        repeat (20) begin
            acc |= {4'd0, eth_tx_en, busy};
            @(negedge clk);
        end
        check("zero_count_ign", {26'd0, acc}, 0);

        start = 1'b1;
        word_count = 9'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_en", {31'd0, eth_tx_en}, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_en", {31'd0, eth_tx_en}, 0);
        check("rst_mid_txd_busy", {27'd0, eth_txd, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        acc = '0;
        repeat (40) begin
            @(negedge clk);
            acc |= {4'd0, done, eth_tx_en};
        end
        check("rst_no_done", {26'd0, acc}, 0);

        capture(2, -1);
        check("len_after_rst", en_len, 32 + FX);
        check("rst_w0", wd(16), 32'h89ABCDEF);
        check("rst_w1", wd(24), 32'h01234567);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mii_tx_framer.md
# mii_tx_framer

MII Ethernet transmit framer: the transmit-side counterpart of the nibble-capture receive path. On a start pulse it reads a frame payload of 32-bit words from the shared block RAM and drives it onto the PHY's 4-bit MII transmit interface. Each frame is wrapped in preamble and SFD, optionally followed by a CRC-32 FCS, then an enforced inter-frame gap. It runs entirely in the `eth_tx_clk` domain and replaces ad-hoc driving of `eth_tx_en`/`eth_txd`.

## Interface
- `ADDR_W`, 9, block RAM word-address width.
- `PREAMBLE_NIBBLES`, 15, count of 0x5 nibbles sent before the SFD nibble 0xD.
- `IFG_NIBBLES`, 24, idle cycles after the frame (96 bit times).

Ports:
- `clk`  in  1  — transmit clock, wired to `eth_tx_clk` (25 MHz).
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — one-cycle request to send a frame; sampled only in IDLE.
- `word_count`  in  ADDR_W  — payload length in 32-bit words; sampled with `start`.
- `rd_addr`  out  ADDR_W  — block RAM read address.
- `rd_data`  in  32  — block RAM read data, 1-cycle synchronous latency.
- `busy`  out  1  — high from the cycle after an accepted start until return to IDLE.
- `done`  out  1  — one-cycle pulse on the last IFG cycle.
- `eth_tx_en`  out  1  — MII transmit enable.
- `eth_txd`  out  4  — MII transmit nibble.

## Operation
- States: IDLE → PREAMBLE → SFD → DATA → (FCS) → IFG → IDLE.
- IDLE:
  - `start`=1 with `word_count`≠0 latches the count and sets `rd_addr`=0.
  - Then enters PREAMBLE.
  - `start` with `word_count`=0 is ignored.
  - `start` outside IDLE is ignored.
- PREAMBLE:
  - Drives `PREAMBLE_NIBBLES` cycles of `eth_txd`=0x5 with `eth_tx_en`=1.
- SFD:
  - Drives 0xD for one cycle.
  - On the same cycle, latches `rd_data` (word 0) into the shift register and advances `rd_addr` to 1.
- DATA:
  - Drives 8 nibbles per word.
  - Byte order: `[7:0]` first through `[31:24]`; low nibble of each byte first.
  - On the 8th nibble of word k (k < count−1), latches word k+1 and advances `rd_addr`.
  - After the 8th nibble of the last word, goes to FCS or IFG.
  - `rd_addr` never exceeds `word_count`−1.
- FCS (macro only):
  - Sends 8 nibbles of the final CRC, low nibble first.
- IFG:
  - `eth_tx_en`=0 and `eth_txd`=0 for `IFG_NIBBLES` cycles.
  - `done` pulses on the last cycle, then IDLE.
- No padding: payloads under 60 bytes are sent as-is; padding is the writer's responsibility.
- Outside PREAMBLE/SFD/DATA/FCS, `eth_tx_en`=0 and `eth_txd`=0.
- Counters:
  - Nibble counter: 3 bits, wraps mod 8 within DATA.
  - Word counter: ADDR_W bits, compared against the latched count.

## Timing
- Reset values: `eth_tx_en`=0, `eth_txd`=0, `rd_addr`=0, `busy`=0, `done`=0; state IDLE.
- Reset mid-frame: all outputs clear asynchronously and the frame is abandoned (no FCS, no IFG, no `done`).
- All outputs are registered.
- Start latency: first preamble nibble on cycle N+1 after `start` at cycle N.
- Frame length on wire:
  - `PREAMBLE_NIBBLES`+1+8·count (+8 with FCS) cycles of `eth_tx_en`=1, contiguous, no gaps.
- RAM timing:
  - `rd_addr` is stable for ≥1 cycle before each latch.
  - Word 0 address is valid for the whole preamble.
- Back-to-back: a `start` on the `done` cycle is ignored.
- `start` is accepted from the first IDLE cycle after `done`.

## Configuration
- `MII_TX_FCS_EN` defined:
  - CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF) is updated per data nibble.
  - The result is inverted and appended as 8 FCS nibbles.
  - SFD/preamble are excluded from the CRC.
- `MII_TX_FCS_EN` undefined:
  - No CRC logic.
  - IFG follows the last data nibble directly.
  - Frame is 8 cycles shorter.

## Test plan
- Reset, then idle 50 cycles -> `eth_tx_en`=0, `eth_txd`=0, `busy`=0 throughout.
- RAM[0]=0x44332211, `word_count`=1, FCS off, `start` -> 15×0x5, 0xD, then 1,1,2,2,3,3,4,4; `eth_tx_en` high 24 cycles; `done` 24 cycles after `eth_tx_en` falls.
- RAM[0]=0x00000000, `word_count`=1, FCS on -> data nibbles 0×8, then FCS nibbles C,1,F,D,4,4,1,2 (CRC 0x2144DF1C).
- `word_count`=3 with distinct words -> `rd_addr` sequence 0,1,2, advancing on the SFD cycle and each 8th nibble; 24 data nibbles in order; `rd_addr` never 3.
- `start` asserted mid-DATA, and `start` with `word_count`=0 in IDLE -> both ignored; the running frame is unaltered.
- `rst` asserted during the 5th data nibble -> `eth_tx_en`=0 immediately; no `done`; next `start` produces a full clean frame.
